softmax_row_sequencer: RTL

Control and buffering block that sequences one row of the softmax datapath through its three passes: max search, exponent/sum, and normalize. It sits between the row input stream and the shared exponent and divide units. It buffers a row of up to MAX_LEN signed Q16.16 words, issues one request at a time to each external unit, and emits the normalized row as an output stream.

---
 rtl/softmax_row_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/softmax_row_sequencer.sv
// rtl/softmax_row_sequencer.sv - softmax row sequencer: load, max search, exp/sum, normalize passes
// Buffers one row, drives the shared exp and divide units one request at a time, streams quotients out.
module softmax_row_sequencer #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 64,
    parameter int SUM_W   = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              exp_req_valid,
    input  logic              exp_req_ready,
    output logic [DATA_W-1:0] exp_req_data,
    input  logic              exp_rsp_valid,
    input  logic [DATA_W-1:0] exp_rsp_data,
    output logic              div_req_valid,
    input  logic              div_req_ready,
    output logic [DATA_W-1:0] div_num,
    output logic [SUM_W-1:0]  div_den,
    input  logic              div_rsp_valid,
    input  logic [DATA_W-1:0] div_rsp_data,
    output logic              busy,
    output logic              overflow,
    output logic              sat
);
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, LOAD, MAX, EXP_REQ, EXP_WAIT, DIV_REQ, DIV_WAIT, OUT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] buffer [MAX_LEN];
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     i;
    logic [IW:0]       len;
    logic [IW:0]       cnt;
    logic [DATA_W-1:0] max_val;
    logic [DATA_W-1:0] rd_data;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W:0]    sum_add;
    logic [SUM_W-1:0]  sum_next;
    logic              sum_ovf;
    logic              last_i;
    logic              max_upd;
    logic [DATA_W-1:0] max_next;

    // x - max never exceeds zero, so only the negative rail needs clamping.
    function automatic logic [DATA_W-1:0] sat_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] d;
        d = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (d[DATA_W] && !d[DATA_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        return d[DATA_W-1:0];
    endfunction

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);
    assign sum_add  = {1'b0, sum} + (SUM_W+1)'(exp_rsp_data);
    assign sum_ovf  = sum_add[SUM_W];
    assign sum_next = sum_ovf ? '1 : sum_add[SUM_W-1:0];
    assign last_i   = ({1'b0, i} == (len - (IW+1)'(1)));
    // rd_data lags cnt by one cycle, so cnt==0 has nothing valid to compare yet.
    assign max_upd  = (cnt != '0) && ($signed(rd_data) > $signed(max_val));
    assign max_next = max_upd ? rd_data : max_val;

    always_ff @(posedge clk) begin
        if (in_ready && in_valid)
            buffer[wr_idx] <= in_data;
        else if (state == EXP_WAIT && exp_rsp_valid)
            buffer[i] <= exp_rsp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_idx        <= '0;
            i             <= '0;
            len           <= '0;
            cnt           <= '0;
            max_val       <= '0;
            rd_data       <= '0;
            sum           <= '0;
            sat           <= 1'b0;
            overflow      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            exp_req_valid <= 1'b0;
            exp_req_data  <= '0;
            div_req_valid <= 1'b0;
            div_num       <= '0;
            div_den       <= '0;
        end else begin
            overflow <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        wr_idx <= wr_idx + IW'(1);
                        if (state == IDLE) begin
                            max_val <= in_data;
                            sat     <= 1'b0;
                            state   <= LOAD;
                        end
                        if (in_last || wr_idx == IW'(MAX_LEN - 1)) begin
                            len      <= {1'b0, wr_idx} + (IW+1)'(1);
                            wr_idx   <= '0;
                            cnt      <= '0;
                            overflow <= !in_last;
                            state    <= MAX;
                        end
                    end
                end
                MAX: begin
                    cnt <= cnt + (IW+1)'(1);
                    if (cnt < len)
                        rd_data <= buffer[cnt[IW-1:0]];
                    max_val <= max_next;
                    if (cnt == len) begin
                        sum           <= '0;
                        i             <= '0;
                        exp_req_valid <= 1'b1;
                        exp_req_data  <= sat_diff(buffer[0], max_next);
                        state         <= EXP_REQ;
                    end
                end
                EXP_REQ: begin
                    if (exp_req_ready) begin
                        exp_req_valid <= 1'b0;
                        state         <= EXP_WAIT;
                    end
                end
                EXP_WAIT: begin
                    if (exp_rsp_valid) begin
                        sum <= sum_next;
                        if (sum_ovf)
                            sat <= 1'b1;
                        if (last_i) begin
                            i             <= '0;
                            div_req_valid <= 1'b1;
                            // a one-word row is overwriting buffer[0] on this very edge
                            div_num       <= (i == '0) ? exp_rsp_data : buffer[0];
                            div_den       <= sum_next;
                            state         <= DIV_REQ;
                        end else begin
                            i             <= i + IW'(1);
                            exp_req_valid <= 1'b1;
                            exp_req_data  <= sat_diff(buffer[i + IW'(1)], max_val);
                            state         <= EXP_REQ;
                        end
                    end
                end
                DIV_REQ: begin
                    if (div_req_ready) begin
                        div_req_valid <= 1'b0;
                        state         <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    if (div_rsp_valid) begin
                        out_data  <= div_rsp_data;
                        out_valid <= 1'b1;
                        out_last  <= last_i;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (last_i) begin
                            i     <= '0;
                            state <= IDLE;
                        end else begin
                            i             <= i + IW'(1);
                            div_req_valid <= 1'b1;
                            div_num       <= buffer[i + IW'(1)];
                            state         <= DIV_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
